pipeline_debug_controller: RTL and testbench
============================================

// Module: pipeline_debug_controller
// PURPOSE
//   Sequences the 5-stage MIPS pipeline for the debug unit: continuous run, single step,
//   drain on HALT, register-bank dump. Owns the global pipeline enable/flush and the bank's
//   debug read port. Sits between the UART command decoder and the pipeline stages.
// PARAMETERS
//   NB_DATA      32  register width; dumped as NB_DATA/8 bytes, LSB first
//   NB_REG_ADDR  5   register-bank address width
//   N_REGS       32  registers dumped per 'r' command (addresses 0..N_REGS-1)
//   DRAIN_CYCLES 4   enabled cycles after HALT is seen in ID so EX/MEM/WB retire
// PORTS
//   i_clk           in   1            clock, rising edge
//   i_reset_n       in   1            asynchronous reset, active low
//   i_cmd_valid     in   1            command byte valid
//   i_cmd           in   8            command byte: 'c' 8'h63, 's' 8'h73, 'r' 8'h72, 'x' 8'h78
//   o_cmd_ready     out  1            command accepted this cycle when valid&ready
//   i_halt          in   1            HALT instruction present in ID (o_halt of decode stage)
//   o_pipe_enable   out  1            global stage enable (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   o_pipe_flush    out  1            one-cycle synchronous pipeline clear
//   o_dbg_reg_addr  out  NB_REG_ADDR  bank debug read address
//   i_dbg_reg_data  in   NB_DATA      bank debug read data, combinational from o_dbg_reg_addr
//   o_tx_valid      out  1            dump byte valid
//   o_tx_data       out  8            dump byte
//   i_tx_ready      in   1            UART TX can take a byte
//   o_state         out  3            current FSM state encoding (below)
//   o_busy          out  1            1 in RUN, STEP, DRAIN, DUMP
// BEHAVIOUR
//   Reset (async, i_reset_n=0): state IDLE, all registered outputs 0, counters 0; applies
//     immediately mid-run/mid-dump; a partial dump is abandoned, no further bytes sent.
//   States: IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4 DUMP=5. o_cmd_ready=1 only in IDLE/HALTED.
//   IDLE: 'c'->RUN, 's'->STEP, 'r'->DUMP (return IDLE), 'x'->flush, stay IDLE. i_halt ignored.
//   HALTED: 'r'->DUMP (return HALTED), 'x'->flush, go IDLE; 'c','s' consumed, ignored.
//   Unknown command bytes: consumed (ready=1), no state change.
//   o_pipe_flush: high exactly the cycle after the 'x' handshake; o_pipe_enable 0 then.
//   RUN: o_pipe_enable=1 every cycle; i_halt=1 -> DRAIN, counter loaded DRAIN_CYCLES.
//   STEP: o_pipe_enable=1 for exactly one cycle; i_halt=1 that cycle -> DRAIN, else IDLE.
//   DRAIN: o_pipe_enable=1 while counter>0, decrement each cycle; at 0 -> HALTED with
//     enable 0 the same cycle. i_halt during DRAIN does not reload. DRAIN_CYCLES=0 -> HALTED
//     on the next cycle.
//   DUMP: o_pipe_enable=0. For addr 0..N_REGS-1: drive o_dbg_reg_addr, latch i_dbg_reg_data
//     one cycle later, emit NB_DATA/8 bytes LSB first. o_tx_valid held, o_tx_data stable until
//     i_tx_ready; one byte per valid&ready cycle. After the last byte of addr N_REGS-1 -> the
//     return state, o_dbg_reg_addr back to 0. Total N_REGS*NB_DATA/8 bytes (128 default).
//   i_tx_ready high with o_tx_valid low has no effect. Counters never wrap past N_REGS-1.
// TESTING
//   Reset, 'c', i_halt asserted at cycle 10 -> enable high 10+4 cycles total, then HALTED(4),
//     enable 0, o_busy 0.
//   Three 's' commands, no halt -> exactly 3 single-cycle enable pulses, state back to IDLE.
//   Bank preloaded reg[n]=32'hA0B0C000+n, 'r', i_tx_ready=1 -> 128 bytes, first four
//     00,C0,B0,A0, last four 1F,C0,B0,A0, then IDLE.
//   'r' with i_tx_ready toggling 1-of-3 cycles -> same 128-byte stream, no dup/drop bytes.
//   In HALTED: 'c' -> ignored; 'x' -> one flush pulse, IDLE; subsequent 'c' -> RUN.
//   i_reset_n low mid-dump at byte 50 -> outputs 0 at once, IDLE, no bytes after release.

Source files
------------

// File: rtl/pipeline_debug_controller.sv
// Debug-unit sequencer for the 5-stage pipeline: continuous run, single step,
// drain on HALT and a byte-serial dump of the register bank over the UART TX path.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | pipeline stopped, accepting commands
//   RUN    | pipeline enabled every cycle until HALT reaches ID
//   STEP   | pipeline enabled for a single cycle
//   DRAIN  | HALT seen; keep enabling until EX/MEM/WB have retired
//   HALTED | program finished; accepts dump or flush
//   DUMP   | streaming register bank bytes, LSB first, then back to caller
module pipeline_debug_controller #(
   parameter int NB_DATA      = 32,
   parameter int NB_REG_ADDR  = 5,
   parameter int N_REGS       = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_cmd_valid,
   input  logic [7:0]             i_cmd,
   output logic                   o_cmd_ready,
   input  logic                   i_halt,
   output logic                   o_pipe_enable,
   output logic                   o_pipe_flush,
   output logic [NB_REG_ADDR-1:0] o_dbg_reg_addr,
   input  logic [NB_DATA-1:0]     i_dbg_reg_data,
   output logic                   o_tx_valid,
   output logic [7:0]             o_tx_data,
   input  logic                   i_tx_ready,
   output logic [2:0]             o_state,
   output logic                   o_busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] STEP   = 3'd2;
   localparam logic [2:0] DRAIN  = 3'd3;
   localparam logic [2:0] HALTED = 3'd4;
   localparam logic [2:0] DUMP   = 3'd5;

   localparam logic [7:0] CMD_C = 8'h63;
   localparam logic [7:0] CMD_S = 8'h73;
   localparam logic [7:0] CMD_R = 8'h72;
   localparam logic [7:0] CMD_X = 8'h78;

   localparam int NB_BYTES = NB_DATA / 8;
   localparam int NB_BIDX  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam int NB_DRAIN = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

   localparam logic [NB_BIDX-1:0]     LAST_BYTE = NB_BIDX'(NB_BYTES - 1);
   localparam logic [NB_REG_ADDR-1:0] LAST_REG  = NB_REG_ADDR'(N_REGS - 1);
   localparam logic [NB_DRAIN-1:0]    DRAIN_LD  = NB_DRAIN'(DRAIN_CYCLES);

   logic [2:0]             state;
   logic [2:0]             ret_state;
   logic [NB_DRAIN-1:0]    drain_cnt;
   logic                   flush_q;
   logic [NB_REG_ADDR-1:0] dump_addr;
   logic [NB_BIDX-1:0]     byte_idx;
   logic [NB_DATA-1:0]     shift_q;
   logic                   tx_valid_q;
   logic                   cmd_hs;

   assign o_cmd_ready    = (state == IDLE) || (state == HALTED);
   assign cmd_hs         = i_cmd_valid && o_cmd_ready;
   assign o_busy         = (state == RUN) || (state == STEP) || (state == DRAIN) || (state == DUMP);
   assign o_state        = state;
   assign o_pipe_flush   = flush_q;
   assign o_dbg_reg_addr = dump_addr;
   assign o_tx_valid     = tx_valid_q;
   assign o_tx_data      = shift_q[7:0];

   // Stage enable: run/step always, drain only while retire cycles remain.
   always_comb begin
      o_pipe_enable = 1'b0;
      case (state)
         RUN, STEP: o_pipe_enable = 1'b1;
         DRAIN:     o_pipe_enable = (drain_cnt != '0);
         default:   o_pipe_enable = 1'b0;
      endcase
   end

   // Sequencer state, drain timer and dump byte engine.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         ret_state  <= IDLE;
         drain_cnt  <= '0;
         flush_q    <= 1'b0;
         dump_addr  <= '0;
         byte_idx   <= '0;
         shift_q    <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         flush_q <= cmd_hs && (i_cmd == CMD_X);
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  case (i_cmd)
                     CMD_C: state <= RUN;
                     CMD_S: state <= STEP;
                     CMD_R: begin
                        state     <= DUMP;
                        ret_state <= IDLE;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
            HALTED: begin
               if (cmd_hs) begin
                  case (i_cmd)
                     CMD_R: begin
                        state     <= DUMP;
                        ret_state <= HALTED;
                     end
                     CMD_X:   state <= IDLE;
                     default: state <= HALTED;
                  endcase
               end
            end
            RUN: begin
               if (i_halt) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LD;
               end
            end
            STEP: begin
               if (i_halt) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LD;
               end else begin
                  state <= IDLE;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= HALTED;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DUMP: begin
               // The read address was driven for a full cycle before the word is captured.
               if (!tx_valid_q) begin
                  shift_q    <= i_dbg_reg_data;
                  tx_valid_q <= 1'b1;
                  byte_idx   <= '0;
               end else if (i_tx_ready) begin
                  if (byte_idx == LAST_BYTE) begin
                     tx_valid_q <= 1'b0;
                     byte_idx   <= '0;
                     if (dump_addr == LAST_REG) begin
                        dump_addr <= '0;
                        state     <= ret_state;
                     end else begin
                        dump_addr <= dump_addr + 1'b1;
                     end
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     shift_q  <= shift_q >> 8;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Bench for the pipeline debug controller: directed scenarios plus a random command
// soak, all checked every cycle against a behavioural model of the sequencer.
module tb_pipeline_debug_controller;

   localparam int NB_DATA      = 32;
   localparam int NB_REG_ADDR  = 5;
   localparam int N_REGS       = 32;
   localparam int DRAIN_CYCLES = 4;
   localparam int N_BYTES      = N_REGS * NB_DATA / 8;

   logic                   i_clk = 1'b0;
   logic                   i_reset_n;
   logic                   i_cmd_valid;
   logic [7:0]             i_cmd;
   logic                   o_cmd_ready;
   logic                   i_halt;
   logic                   o_pipe_enable;
   logic                   o_pipe_flush;
   logic [NB_REG_ADDR-1:0] o_dbg_reg_addr;
   logic [NB_DATA-1:0]     i_dbg_reg_data;
   logic                   o_tx_valid;
   logic [7:0]             o_tx_data;
   logic                   i_tx_ready;
   logic [2:0]             o_state;
   logic                   o_busy;

   logic [NB_DATA-1:0] bank [N_REGS];
   assign i_dbg_reg_data = bank[o_dbg_reg_addr];

   pipeline_debug_controller #(
      .NB_DATA(NB_DATA), .NB_REG_ADDR(NB_REG_ADDR),
      .N_REGS(N_REGS), .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
      .i_halt(i_halt), .o_pipe_enable(o_pipe_enable), .o_pipe_flush(o_pipe_flush),
      .o_dbg_reg_addr(o_dbg_reg_addr), .i_dbg_reg_data(i_dbg_reg_data),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
      .o_state(o_state), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Spec state numbers: 0 idle, 1 run, 2 step, 3 drain, 4 halted, 5 dump.
   int  m_state = 0;
   int  m_ret   = 0;
   int  m_drain = 0;
   int  m_bidx  = 0;
   bit  m_flush = 0;
   bit  hs_tx   = 0;
   int  en_count = 0;
   logic [7:0] stream [$];

   function automatic logic [7:0] exp_byte(input int k);
      logic [NB_DATA-1:0] w;
      w = bank[k / 4];
      return w[8 * (k % 4) +: 8];
   endfunction

   always @(posedge i_clk or negedge i_reset_n) begin
      bit acc;
      if (!i_reset_n) begin
         m_state = 0; m_ret = 0; m_drain = 0; m_bidx = 0; m_flush = 0;
      end else begin
         acc = i_cmd_valid && (m_state == 0 || m_state == 4);
         m_flush = acc && (i_cmd == 8'h78);
         case (m_state)
            0: if (acc) begin
                  if (i_cmd == 8'h63) m_state = 1;
                  else if (i_cmd == 8'h73) m_state = 2;
                  else if (i_cmd == 8'h72) begin m_state = 5; m_ret = 0; m_bidx = 0; end
               end
            4: if (acc) begin
                  if (i_cmd == 8'h72) begin m_state = 5; m_ret = 4; m_bidx = 0; end
                  else if (i_cmd == 8'h78) m_state = 0;
               end
            1: if (i_halt) begin m_state = 3; m_drain = DRAIN_CYCLES; end
            2: if (i_halt) begin m_state = 3; m_drain = DRAIN_CYCLES; end
               else m_state = 0;
            3: if (m_drain == 0) m_state = 4; else m_drain--;
            5: if (hs_tx) begin
                  m_bidx++;
                  if (m_bidx == N_BYTES) m_state = m_ret;
               end
            default: m_state = 0;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge i_clk) begin
      chk("state", o_state, m_state);
      chk("cmd_ready", o_cmd_ready, (m_state == 0 || m_state == 4));
      chk("busy", o_busy, (m_state >= 1 && m_state <= 3) || m_state == 5);
      chk("pipe_enable", o_pipe_enable,
          (m_state == 1 || m_state == 2 || (m_state == 3 && m_drain > 0)));
      chk("pipe_flush", o_pipe_flush, m_flush);
      if (m_state != 5) begin
         chk("tx_valid_idle", o_tx_valid, 0);
         chk("dbg_addr_idle", o_dbg_reg_addr, 0);
      end else if (o_tx_valid) begin
         chk("tx_in_range", (m_bidx < N_BYTES), 1);
         if (m_bidx < N_BYTES) chk("tx_data", o_tx_data, exp_byte(m_bidx));
      end
      hs_tx = o_tx_valid && i_tx_ready && (m_state == 5);
      if (hs_tx) stream.push_back(o_tx_data);
      if (o_pipe_enable) en_count++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      int n;
      n = 0;
      i_cmd = c;
      i_cmd_valid = 1'b1;
      while (!o_cmd_ready && n < 300) begin tick(1); n++; end
      chk("cmd_accept_timeout", o_cmd_ready, 1);
      tick(1);
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int n;
      n = 0;
      while (o_state != 3'(s) && n < budget) begin tick(1); n++; end
      chk(name, o_state, s);
   endtask

   function automatic logic [7:0] lit_byte(input int k);
      int n;
      n = k / 4;
      case (k % 4)
         0:       return n[7:0];
         1:       return 8'hC0;
         2:       return 8'hB0;
         default: return 8'hA0;
      endcase
   endfunction

   task automatic do_reset();
      i_reset_n = 1'b0;
      tick(2);
      i_reset_n = 1'b1;
      tick(1);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int base, sbase, n;
      logic [7:0] cmd_tab [5];
      cmd_tab[0] = 8'h63; cmd_tab[1] = 8'h73; cmd_tab[2] = 8'h72;
      cmd_tab[3] = 8'h78; cmd_tab[4] = 8'h00;

      i_reset_n = 1'b1; i_cmd_valid = 1'b0; i_cmd = 8'h00;
      i_halt = 1'b0; i_tx_ready = 1'b0;
      for (int i = 0; i < N_REGS; i++) bank[i] = 32'hA0B0C000 + 32'(i);
      #1 i_reset_n = 1'b0;
      #1;
      chk("reset_state", o_state, 0);
      chk("reset_tx_valid", o_tx_valid, 0);
      chk("reset_enable", o_pipe_enable, 0);
      chk("reset_flush", o_pipe_flush, 0);
      tick(2);
      i_reset_n = 1'b1;
      tick(1);

      // Run, HALT in the 10th run cycle: 10 run + 4 drain enables.
      base = en_count;
      send_cmd(8'h63);
      chk("run_entered", o_state, 1);
      tick(9);
      i_halt = 1'b1;
      tick(1);
      i_halt = 1'b0;
      wait_state(4, 30, "drain_to_halted");
      tick(3);
      chk("run_halt_enables", en_count - base, 14);
      chk("halted_enable", o_pipe_enable, 0);
      chk("halted_busy", o_busy, 0);

      // HALTED: 'c' ignored, 'x' flushes to IDLE, then 'c' runs again.
      base = en_count;
      send_cmd(8'h63);
      tick(2);
      chk("halted_c_ignored", o_state, 4);
      chk("halted_c_no_enable", en_count - base, 0);
      send_cmd(8'h78);
      chk("x_flush_pulse", o_pipe_flush, 1);
      chk("x_to_idle", o_state, 0);
      chk("x_flush_enable", o_pipe_enable, 0);
      tick(1);
      chk("x_flush_single", o_pipe_flush, 0);
      send_cmd(8'h63);
      chk("c_after_x_runs", o_state, 1);
      i_halt = 1'b1;
      tick(1);
      i_halt = 1'b0;
      wait_state(4, 30, "second_halt");
      send_cmd(8'h78);
      tick(1);

      // Three single steps with no HALT.
      base = en_count;
      for (int i = 0; i < 3; i++) begin
         send_cmd(8'h73);
         tick(2);
      end
      chk("step_pulses", en_count - base, 3);
      chk("step_back_idle", o_state, 0);

      // Dump with TX always ready.
      i_tx_ready = 1'b1;
      sbase = stream.size();
      send_cmd(8'h72);
      wait_state(0, 1000, "dump_return_idle");
      chk("dump_count", stream.size() - sbase, N_BYTES);
      if (stream.size() - sbase == N_BYTES) begin
         for (int k = 0; k < N_BYTES; k++)
            chk($sformatf("dump_byte_%0d", k), stream[sbase + k], lit_byte(k));
         chk("dump_first0", stream[sbase + 0], 8'h00);
         chk("dump_first3", stream[sbase + 3], 8'hA0);
         chk("dump_last0", stream[sbase + N_BYTES - 4], 8'h1F);
         chk("dump_last1", stream[sbase + N_BYTES - 3], 8'hC0);
      end

      // Dump with TX ready one cycle in three.
      i_tx_ready = 1'b0;
      sbase = stream.size();
      send_cmd(8'h72);
      n = 0;
      while (o_state != 3'd0 && n < 2000) begin
         i_tx_ready = (n % 3 == 0);
         tick(1);
         n++;
      end
      i_tx_ready = 1'b0;
      chk("slow_dump_return_idle", o_state, 0);
      chk("slow_dump_count", stream.size() - sbase, N_BYTES);
      if (stream.size() - sbase == N_BYTES)
         for (int k = 0; k < N_BYTES; k++)
            chk($sformatf("slow_byte_%0d", k), stream[sbase + k], lit_byte(k));

      // Reset in the middle of a dump after 50 bytes.
      i_tx_ready = 1'b1;
      sbase = stream.size();
      send_cmd(8'h72);
      n = 0;
      while (stream.size() - sbase < 50 && n < 500) begin tick(1); n++; end
      chk("reached_byte_50", stream.size() - sbase, 50);
      #2 i_reset_n = 1'b0;
      #1;
      chk("midreset_state", o_state, 0);
      chk("midreset_tx_valid", o_tx_valid, 0);
      chk("midreset_addr", o_dbg_reg_addr, 0);
      chk("midreset_busy", o_busy, 0);
      tick(2);
      i_reset_n = 1'b1;
      sbase = stream.size();
      tick(20);
      chk("no_bytes_after_reset", stream.size() - sbase, 0);
      chk("idle_after_reset", o_state, 0);
      i_tx_ready = 1'b0;

      // Random soak against the model with a random register bank.
      for (int i = 0; i < N_REGS; i++) bank[i] = $urandom;
      for (int c = 0; c < 4000; c++) begin
         i_cmd_valid = ($urandom_range(0, 3) == 0);
         i_cmd = cmd_tab[$urandom_range(0, 4)];
         if (i_cmd == 8'h00) i_cmd = 8'($urandom);
         i_halt = ($urandom_range(0, 7) == 0);
         i_tx_ready = $urandom_range(0, 1) == 1;
         tick(1);
      end
      i_cmd_valid = 1'b0; i_halt = 1'b0; i_tx_ready = 1'b0;
      do_reset();
      chk("final_idle", o_state, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
